// File: rtl/cursor_overlay_pkg.sv
// Shared definitions for the cursor overlay: click FSM states, default
// colours and the 2-bit sprite pixel codes, plus the arrow bitmap rule.
package cursor_overlay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HOLD  = 2'd2,
    ST_CLICK = 2'd3
  } state_t;

  localparam logic [11:0] COL_IDLE_DEF  = 12'hFFF;
  localparam logic [11:0] COL_LEFT_DEF  = 12'hF00;
  localparam logic [11:0] COL_RIGHT_DEF = 12'h0F0;
  localparam logic [11:0] COL_EDGE_DEF  = 12'h000;

  localparam logic [1:0] CODE_TRANSP = 2'b00;
  localparam logic [1:0] CODE_EDGE   = 2'b01;
  localparam logic [1:0] CODE_FILL   = 2'b10;
  localparam logic [1:0] CODE_RSVD   = 2'b11;

  // Arrow shape: a right triangle in the top three quarters (outlined, filled
  // inside, closed by a full bottom edge row) and a three-pixel diagonal tail.
  function automatic logic [1:0] arrow_code(input int row, input int col,
                                            input int w, input int h);
    int body_h;
    int k;
    body_h     = (h * 3) / 4;
    k          = body_h / 2;
    arrow_code = CODE_TRANSP;
    if (col < w) begin
      if (row < body_h) begin
        if (col <= row) begin
          if (col == 0 || col == row || row == body_h - 1) arrow_code = CODE_EDGE;
          else                                            arrow_code = CODE_FILL;
        end
      end else begin
        if (col == row - k || col == row - k + 2) arrow_code = CODE_EDGE;
        else if (col == row - k + 1)              arrow_code = CODE_FILL;
      end
    end
  endfunction

endpackage

// File: rtl/cursor_overlay_rom.sv
// Cursor sprite ROM: CUR_W x CUR_H arrow bitmap, 2 bits per pixel,
// synchronous read with one clock of latency.
module cursor_rom
  import cursor_overlay_pkg::*;
#(
  parameter int CUR_W = 16,
  parameter int CUR_H = 16,
  parameter int AW_X  = 4,
  parameter int AW_Y  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW_Y+AW_X-1:0] i_addr,
  output logic [1:0]           o_code
);

  logic [1:0] r_code;

  // Registered lookup; address is {row, col}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_code <= CODE_TRANSP;
    else     r_code <= arrow_code(int'(i_addr[AW_Y+AW_X-1:AW_X]), int'(i_addr[AW_X-1:0]),
                                  CUR_W, CUR_H);
  end

  assign o_code = r_code;

endmodule

// File: rtl/cursor_overlay.sv
// Mouse cursor overlay for a VGA pixel stream: frame-synchronous cursor
// latch, two-stage sprite overlay pipeline and a left-button click/hold FSM.
module cursor_overlay
  import cursor_overlay_pkg::*;
#(
  parameter int          CUR_W       = 16,
  parameter int          CUR_H       = 16,
  parameter int          HOLD_FRAMES = 30,
  parameter logic [11:0] COL_IDLE    = COL_IDLE_DEF,
  parameter logic [11:0] COL_LEFT    = COL_LEFT_DEF,
  parameter logic [11:0] COL_RIGHT   = COL_RIGHT_DEF,
  parameter logic [11:0] COL_EDGE    = COL_EDGE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  mouse_x,
  input  logic [9:0]  mouse_y,
  input  logic [2:0]  btnm,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        frame_tick,
  input  logic [11:0] rgb_in,
  output logic [11:0] rgb_out,
  output logic        video_on_out,
  output logic        click_tick,
  output logic [9:0]  click_x,
  output logic [9:0]  click_y,
  output logic        hold
);

  localparam int AW_X  = (CUR_W > 1) ? $clog2(CUR_W) : 1;
  localparam int AW_Y  = (CUR_H > 1) ? $clog2(CUR_H) : 1;
  localparam int CNT_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CNT_W:0] CNT_LAST = (CNT_W+1)'(HOLD_FRAMES - 1);

  // Left beats right; middle button does not colour the cursor.
  function automatic logic [11:0] fill_colour(input logic [1:0] btn);
    if (btn[0])      fill_colour = COL_LEFT;
    else if (btn[1]) fill_colour = COL_RIGHT;
    else             fill_colour = COL_IDLE;
  endfunction

  logic [9:0]           r_cur_x, r_cur_y;
  logic [2:0]           r_cur_btn;
  logic                 w_unused_btn;
  logic [10:0]          w_x_end, w_y_end;
  logic                 w_hit;
  logic [AW_X-1:0]      w_dx;
  logic [AW_Y-1:0]      w_dy;
  logic [AW_Y+AW_X-1:0] w_addr;
  logic                 r_hit_p1, r_vld_p1;
  logic [11:0]          r_rgb_p1, r_fill_p1;
  logic [1:0]           w_code_p1;
  logic [11:0]          w_pix_p1;
  logic [11:0]          r_rgb_p2;
  logic                 r_vld_p2;
  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [CNT_W:0]       w_cnt_inc;
  logic                 w_press_ld;
  logic [9:0]           r_press_x, r_press_y, r_click_x, r_click_y;

  assign w_unused_btn = r_cur_btn[2];

  // Cursor position and buttons only change at frame start so the sprite never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_x   <= '0;
      r_cur_y   <= '0;
      r_cur_btn <= '0;
    end else if (frame_tick) begin
      r_cur_x   <= mouse_x;
      r_cur_y   <= mouse_y;
      r_cur_btn <= btnm;
    end
  end

  // Hit window end is computed in 11 bits so a cursor near 1023 never wraps to column 0.
  assign w_x_end = {1'b0, r_cur_x} + 11'(CUR_W);
  assign w_y_end = {1'b0, r_cur_y} + 11'(CUR_H);
  assign w_hit   = ({1'b0, pixel_x} >= {1'b0, r_cur_x}) && ({1'b0, pixel_x} < w_x_end) &&
                   ({1'b0, pixel_y} >= {1'b0, r_cur_y}) && ({1'b0, pixel_y} < w_y_end);
  assign w_dx    = AW_X'(pixel_x - r_cur_x);
  assign w_dy    = AW_Y'(pixel_y - r_cur_y);
  assign w_addr  = w_hit ? {w_dy, w_dx} : '0;

  // ---- stage 0 -> stage 1 boundary (ROM registers its code in parallel) ----
  cursor_rom #(
    .CUR_W (CUR_W),
    .CUR_H (CUR_H),
    .AW_X  (AW_X),
    .AW_Y  (AW_Y)
  ) u_rom (
    .clk    (clk),
    .rst    (rst),
    .i_addr (w_addr),
    .o_code (w_code_p1)
  );

  // Stage 1 registers: hit flag, fill colour of this pixel's frame, background, video_on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_p1  <= 1'b0;
      r_fill_p1 <= '0;
      r_rgb_p1  <= '0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_hit_p1  <= w_hit;
      r_fill_p1 <= fill_colour(r_cur_btn[1:0]);
      r_rgb_p1  <= rgb_in;
      r_vld_p1  <= video_on;
    end
  end

  // Overlay mux: outline, fill or background; blanking forces black.
  always_comb begin
    w_pix_p1 = r_rgb_p1;
    if (r_hit_p1) begin
      case (w_code_p1)
        CODE_EDGE:              w_pix_p1 = COL_EDGE;
        CODE_FILL:              w_pix_p1 = r_fill_p1;
        CODE_TRANSP, CODE_RSVD: w_pix_p1 = r_rgb_p1;
        default:                w_pix_p1 = r_rgb_p1;
      endcase
    end
    if (!r_vld_p1) w_pix_p1 = 12'h000;
  end

  // ---- stage 1 -> stage 2 boundary ----
  // Stage 2 registers the overlaid colour and the aligned video_on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb_p2 <= '0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_rgb_p2 <= w_pix_p1;
      r_vld_p2 <= r_vld_p1;
    end
  end

  assign rgb_out      = r_rgb_p2;
  assign video_on_out = r_vld_p2;

  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);

  // Click FSM next state: steps on frame_tick only, except CLICK which lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press_ld  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (frame_tick && btnm[0]) begin
          w_state_nxt = ST_PRESS;
          w_cnt_nxt   = '0;
          w_press_ld  = 1'b1;
        end
      end
      ST_PRESS: begin
        if (frame_tick) begin
          if (!btnm[0]) begin
            w_state_nxt = ST_CLICK;
          end else begin
            w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
            if (w_cnt_inc >= CNT_LAST) w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (frame_tick && !btnm[0]) w_state_nxt = ST_IDLE;
      end
      ST_CLICK: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Click FSM state, frame counter, press position and the reported click position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_press_x <= '0;
      r_press_y <= '0;
      r_click_x <= '0;
      r_click_y <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_press_ld) begin
        r_press_x <= mouse_x;
        r_press_y <= mouse_y;
      end
      // Load on entry to CLICK so the position is valid while click_tick is high.
      if (w_state_nxt == ST_CLICK) begin
        r_click_x <= r_press_x;
        r_click_y <= r_press_y;
      end
    end
  end

  assign click_tick = (r_state == ST_CLICK);
  assign hold       = (r_state == ST_HOLD);
  assign click_x    = r_click_x;
  assign click_y    = r_click_y;

endmodule

// File: doc/cursor_overlay.md
CURSOR_OVERLAY -- requirements
Module: cursor_overlay

Interface
REQ-001 Parameter CUR_W, default 16: cursor sprite width in pixels.
REQ-002 Parameter CUR_H, default 16: cursor sprite height in pixels.
REQ-003 Parameter HOLD_FRAMES, default 30: frames left button must stay down before a press counts as hold, not click.
REQ-004 Parameters COL_IDLE 12'hFFF, COL_LEFT 12'hF00, COL_RIGHT 12'h0F0, COL_EDGE 12'h000: cursor fill and outline colours, 4:4:4 RGB.
REQ-005 Port clk  input  1: single system clock, all logic rising-edge.
REQ-006 Port rst  input  1: asynchronous, active-high reset.
REQ-007 Port mouse_x, mouse_y  input  10 each: pointer position, same counter space as pixel_x/pixel_y.
REQ-008 Port btnm  input  3: [0] left, [1] right, [2] middle, 1 = pressed.
REQ-009 Port pixel_x, pixel_y  input  10 each: current pixel coordinates from the VGA sync generator.
REQ-010 Port video_on  input  1: current pixel is in the visible area.
REQ-011 Port frame_tick  input  1: one-cycle pulse, once per frame, at the start of vertical blanking.
REQ-012 Port rgb_in  input  12: background pixel colour.
REQ-013 Port rgb_out  output  12: background with cursor overlaid.
REQ-014 Port video_on_out  output  1: video_on delayed to align with rgb_out.
REQ-015 Port click_tick  output  1: one-cycle pulse on a completed left click.
REQ-016 Port click_x, click_y  output  10 each: pointer position captured at press start of the last click.
REQ-017 Port hold  output  1: high while the left button is in hold state.

Function
REQ-018 On frame_tick, cur_x, cur_y and cur_btn SHALL latch mouse_x, mouse_y and btnm; otherwise they hold, so the cursor never tears mid-frame.
REQ-019 Hit test: pixel_x >= cur_x and pixel_x < cur_x+CUR_W (11-bit sum, no wrap), and the same for y with CUR_H.
REQ-020 Sprite address = {pixel_y-cur_y, pixel_x-cur_x} truncated to log2 widths; address is valid only on a hit.
REQ-021 Sprite pixel code is 2 bits: 00 transparent, 01 edge, 10 fill, 11 treated as transparent.
REQ-022 Pipeline stage 1 SHALL register hit, sprite address, rgb_in and video_on.
REQ-023 Pipeline stage 2 SHALL register the ROM code and the mux result; rgb_out and video_on_out latency is exactly 2 clocks.
REQ-024 Fill colour: COL_LEFT if cur_btn[0]; else COL_RIGHT if cur_btn[1]; else COL_IDLE. Left wins when left and right are both pressed.
REQ-025 rgb_out SHALL be 12'h000 when delayed video_on = 0; otherwise it is the cursor colour on a hit with a non-transparent code, else the delayed rgb_in.
REQ-026 Click FSM states: IDLE, PRESS, HOLD, CLICK. It advances only on frame_tick, except CLICK, which leaves after one cycle.
REQ-027 IDLE: frame_tick with btnm[0]=1 -> PRESS; cnt=0; press_x/press_y <= mouse_x/mouse_y.
REQ-028 PRESS: frame_tick with btnm[0]=0 -> CLICK; frame_tick with btnm[0]=1 increments cnt; at cnt = HOLD_FRAMES-1 -> HOLD.
REQ-029 HOLD: hold=1; frame_tick with btnm[0]=0 -> IDLE, and no click is generated.
REQ-030 CLICK: click_tick=1 for one cycle; click_x/click_y <= press_x/press_y on the same cycle; -> IDLE unconditionally.
REQ-031 click_x/click_y SHALL hold their value until the next CLICK.
REQ-032 A pixel stream in progress during frame_tick uses the old cur_* for that cycle and the new cur_* from the next cycle.

Reset
REQ-033 Asserting rst at any time SHALL force state=IDLE, cnt=0, cur_x=cur_y=0, cur_btn=0, press_x/y=0, and clear all pipeline registers.
REQ-034 After reset, outputs are: rgb_out=0, video_on_out=0, click_tick=0, click_x=click_y=0, hold=0.
REQ-035 Reset during PRESS or HOLD SHALL abort without a click_tick.

Structure
REQ-036 Shared package holds the FSM state encoding, the colour constants, and the 2-bit sprite code values.
REQ-037 One sub-module, cursor_rom: synchronous-read CUR_W*CUR_H x 2-bit arrow bitmap, 1-cycle latency.

Verification
REQ-038 Latch: mouse=(100,50), frame_tick; scan pixel (100,50) -> rgb_out = COL_EDGE two clocks later; pixel (99,50) -> rgb_in passes through.
REQ-039 Colour: btnm=3'b011 latched, scan a fill pixel -> COL_LEFT; btnm=3'b010 -> COL_RIGHT; video_on=0 -> 12'h000.
REQ-040 Click: left down for 5 frames at (200,120), then up -> single click_tick one cycle after the release frame_tick; click_x=200, click_y=120.
REQ-041 Hold: left down for 40 frames -> hold=1 after 30 frame_ticks; release -> hold=0 and no click_tick.
REQ-042 Edge: cur_x=1016 with CUR_W=16 -> pixel_x 0..7 gives no hit (no wraparound); mouse changes without frame_tick -> cursor does not move.
REQ-043 Reset mid-PRESS: assert rst at frame 3 of a press -> IDLE, no click_tick, all outputs at their reset values.
